onehot_req_arbiter: RTL and testbench

//  Upstream stage of the 8-to-3 encoder. Latches pulsed request lines into a sticky

---
 rtl/onehot_req_arbiter_pkg.sv | 14 +
 rtl/onehot_req_arbiter_pick.sv | 36 +++
 rtl/onehot_req_arbiter.sv | 157 +++++++++++++++
 tb/tb_onehot_req_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/onehot_req_arbiter_pkg.sv
// rtl/onehot_req_arbiter_pkg.sv - shared FSM encodings and default sizes for the request arbiter
package onehot_req_arbiter_pkg;

    // Encodings are fixed so the state can be read directly in a waveform
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    localparam int ARB_N_DEF     = 8;
    localparam int ARB_CNT_W_DEF = 8;

endpackage

// File: rtl/onehot_req_arbiter_pick.sv
// rtl/onehot_req_arbiter_pick.sv - one-hot selector: first set pending bit found from a start index
module onehot_pick
    import onehot_req_arbiter_pkg::*;
#(
    parameter int N     = ARB_N_DEF,
    parameter int IDX_W = 3,
    parameter bit DESC  = 1'b1
) (
    input  logic [N-1:0]     pending,
    input  logic [IDX_W-1:0] start,
    output logic [N-1:0]     sel
);

    // Bit position visited at step k of the wrapping search
    function automatic int pos_of(input int s, input int k);
        if (DESC) begin
            return (s - k + N) % N;
        end
        return (s + k) % N;
    endfunction

    logic found;

    // Walk all N positions from start (wrapping) and mark the first pending one
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && pending[pos_of(int'(start), k)]) begin
                sel[pos_of(int'(start), k)] = 1'b1;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/onehot_req_arbiter.sv
// rtl/onehot_req_arbiter.sv - sticky request latch and one-hot grant issuer; ARB_RR_EN selects round-robin
module onehot_req_arbiter
    import onehot_req_arbiter_pkg::*;
#(
    parameter int N     = ARB_N_DEF,
    parameter int CNT_W = ARB_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_in,
    input  logic             gnt_ack,
    output logic [N-1:0]     gnt,
    output logic             gnt_valid,
    output logic [N-1:0]     pending,
    output logic [CNT_W-1:0] dup_cnt
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int PC_W  = $clog2(N + 1);
    localparam int SUM_W = CNT_W + PC_W;

    arb_state_t       state;
    arb_state_t       state_next;
    logic [N-1:0]     gnt_q;
    logic [N-1:0]     pick_sel;
    logic [N-1:0]     clr_mask;
    logic [N-1:0]     dup_bits;
    logic [IDX_W-1:0] pick_start;
    logic [PC_W-1:0]  dup_pc;
    logic [SUM_W-1:0] dup_sum;
    logic             ack_fire;
    logic             load_grant;

    assign ack_fire   = (state == GRANT) && gnt_ack;
    assign load_grant = (state == IDLE) && (|pending);

`ifdef ARB_RR_EN
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] sel_idx;

    // Search begins one position past the most recently granted bit
    always_comb begin
        pick_start = (ptr == IDX_W'(N - 1)) ? '0 : ptr + 1'b1;
    end

    // Binary index of the selected bit, used to advance the pointer
    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (pick_sel[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
    end

    // Pointer follows each grant as it is issued
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= IDX_W'(N - 1);
        end else if (load_grant) begin
            ptr <= sel_idx;
        end
    end

    onehot_pick #(
        .N     (N),
        .IDX_W (IDX_W),
        .DESC  (1'b0)
    ) u_pick (
        .pending (pending),
        .start   (pick_start),
        .sel     (pick_sel)
    );
`else
    // Fixed priority: scan downward from the top bit
    assign pick_start = IDX_W'(N - 1);

    onehot_pick #(
        .N     (N),
        .IDX_W (IDX_W),
        .DESC  (1'b1)
    ) u_pick (
        .pending (pending),
        .start   (pick_start),
        .sel     (pick_sel)
    );
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE -> GRANT -> (ack) GAP -> IDLE
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (|pending) state_next = GRANT;
            GRANT:   if (gnt_ack)  state_next = GAP;
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Grant is captured once on entry to GRANT so later requests cannot disturb it
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q <= '0;
        end else if (load_grant) begin
            gnt_q <= pick_sel;
        end
    end

    // Outputs: the grant is only visible while in GRANT, keeping the encoder input zero otherwise
    always_comb begin
        gnt_valid = (state == GRANT);
        gnt       = gnt_valid ? gnt_q : '0;
    end

    // Pending latch: new requests OR in; an acked grant clears its bit unless re-requested this edge
    always_comb begin
        clr_mask = ack_fire ? gnt_q : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_mask) | req_in;
        end
    end

    // Count duplicate requests this edge and add them with saturation
    always_comb begin
        dup_bits = req_in & pending;
        dup_pc   = '0;
        for (int i = 0; i < N; i++) begin
            dup_pc = dup_pc + PC_W'(dup_bits[i]);
        end
        dup_sum = SUM_W'(dup_cnt) + SUM_W'(dup_pc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dup_cnt <= '0;
        end else if (dup_sum > SUM_W'({CNT_W{1'b1}})) begin
            dup_cnt <= '1;
        end else begin
            dup_cnt <= dup_sum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_onehot_req_arbiter.sv
// tb/tb_onehot_req_arbiter.sv - directed self-checking bench for onehot_req_arbiter
module tb_onehot_req_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req_in;
    logic       gnt_ack;
    logic [7:0] gnt;
    logic       gnt_valid;
    logic [7:0] pending;
    logic [7:0] dup_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    onehot_req_arbiter #(.N(8), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_in    (req_in),
        .gnt_ack   (gnt_ack),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .pending   (pending),
        .dup_cnt   (dup_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_in = '0; gnt_ack = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_in = 8'hFF; gnt_ack = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_checks++;
            if ({gnt, gnt_valid, pending, dup_cnt} !== 25'd0) begin
                n_fail++;
                $display("FAIL reset cyc%0d: gnt=%h v=%b pend=%h dup=%0d, want all 0", c, gnt, gnt_valid, pending, dup_cnt);
            end
        end
        rst = 1'b0; req_in = '0;
        tick();
        n_checks++;
        if ({gnt_valid, pending} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_release: v=%b pend=%h, want 0 0", gnt_valid, pending);
        end
    endtask

    task automatic test_single_grant();
        do_reset();
        req_in = 8'b0010_0000;
        tick();
        req_in = '0;
        n_checks++;
        if ({pending, gnt_valid, gnt} !== {8'h20, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL single_latch: pend=%h v=%b gnt=%h, want 20 0 00", pending, gnt_valid, gnt);
        end
        tick();
        n_checks++;
        if ({gnt_valid, gnt} !== {1'b1, 8'h20}) begin
            n_fail++;
            $display("FAIL single_grant: v=%b gnt=%h, want 1 20", gnt_valid, gnt);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++;
            if ({gnt_valid, gnt, pending} !== {1'b1, 8'h20, 8'h20}) begin
                n_fail++;
                $display("FAIL single_hold cyc%0d: v=%b gnt=%h pend=%h, want 1 20 20", c, gnt_valid, gnt, pending);
            end
        end
        gnt_ack = 1'b1;
        tick();
        gnt_ack = 1'b0;
        n_checks++;
        if ({gnt_valid, gnt, pending, dup_cnt} !== 25'd0) begin
            n_fail++;
            $display("FAIL single_ack: v=%b gnt=%h pend=%h dup=%0d, want all 0", gnt_valid, gnt, pending, dup_cnt);
        end
        tick();
        tick();
        n_checks++;
        if ({gnt_valid, gnt} !== 9'd0) begin
            n_fail++;
            $display("FAIL single_no_regrant: v=%b gnt=%h, want 0 00", gnt_valid, gnt);
        end
    endtask

    task automatic test_priority();
        logic [7:0] first_g;
        logic [7:0] second_g;
`ifdef ARB_RR_EN
        first_g = 8'h01; second_g = 8'h80;
`else
        first_g = 8'h80; second_g = 8'h01;
`endif
        do_reset();
        req_in = 8'b1000_0001;
        tick();
        req_in = '0;
        tick();
        n_checks++;
        if ({gnt_valid, gnt} !== {1'b1, first_g}) begin
            n_fail++;
            $display("FAIL prio_first: v=%b gnt=%h, want 1 %h", gnt_valid, gnt, first_g);
        end
        gnt_ack = 1'b1;
        tick();
        n_checks++;
        if ({gnt_valid, gnt, pending} !== {1'b0, 8'h00, second_g}) begin
            n_fail++;
            $display("FAIL prio_gap: v=%b gnt=%h pend=%h, want 0 00 %h", gnt_valid, gnt, pending, second_g);
        end
        tick();
        gnt_ack = 1'b0;
        n_checks++;
        if ({gnt_valid, gnt, pending} !== {1'b0, 8'h00, second_g}) begin
            n_fail++;
            $display("FAIL prio_ack_ignored: v=%b gnt=%h pend=%h, want 0 00 %h", gnt_valid, gnt, pending, second_g);
        end
        tick();
        n_checks++;
        if ({gnt_valid, gnt} !== {1'b1, second_g}) begin
            n_fail++;
            $display("FAIL prio_second: v=%b gnt=%h, want 1 %h", gnt_valid, gnt, second_g);
        end
        gnt_ack = 1'b1;
        tick();
        gnt_ack = 1'b0;
        n_checks++;
        if ({gnt_valid, pending} !== 9'd0) begin
            n_fail++;
            $display("FAIL prio_drain: v=%b pend=%h, want 0 00", gnt_valid, pending);
        end
    endtask

    task automatic test_ack_set_same_edge();
        do_reset();
        req_in = 8'b0000_0100;
        tick();
        req_in = '0;
        tick();
        gnt_ack = 1'b1; req_in = 8'b0000_0100;
        tick();
        gnt_ack = 1'b0; req_in = '0;
        n_checks++;
        if ({gnt_valid, pending, dup_cnt} !== {1'b0, 8'h04, 8'd1}) begin
            n_fail++;
            $display("FAIL same_edge: v=%b pend=%h dup=%0d, want 0 04 1", gnt_valid, pending, dup_cnt);
        end
        tick();
        n_checks++;
        if (gnt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL same_edge_idle: v=%b, want 0", gnt_valid);
        end
        tick();
        n_checks++;
        if ({gnt_valid, gnt} !== {1'b1, 8'h04}) begin
            n_fail++;
            $display("FAIL same_edge_regrant: v=%b gnt=%h, want 1 04", gnt_valid, gnt);
        end
    endtask

    task automatic test_dup_count();
        do_reset();
        req_in = 8'h0F;
        tick();
        tick();
        req_in = '0;
        n_checks++;
        if (dup_cnt !== 8'd4) begin
            n_fail++;
            $display("FAIL dup_popcount: dup=%0d, want 4", dup_cnt);
        end
        do_reset();
        req_in = 8'b0000_1000;
        tick();
        req_in = '0;
        for (int p = 0; p < 3; p++) begin
            req_in = 8'b0000_1000;
            tick();
            req_in = '0;
            tick();
        end
        n_checks++;
        if ({dup_cnt, pending} !== {8'd3, 8'h08}) begin
            n_fail++;
            $display("FAIL dup_three: dup=%0d pend=%h, want 3 08", dup_cnt, pending);
        end
        req_in = 8'b0000_1000;
        for (int p = 0; p < 100; p++) tick();
        n_checks++;
        if (dup_cnt !== 8'd103) begin
            n_fail++;
            $display("FAIL dup_mid: dup=%0d, want 103", dup_cnt);
        end
        for (int p = 0; p < 200; p++) tick();
        req_in = '0;
        n_checks++;
        if (dup_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL dup_saturate: dup=%0d, want 255", dup_cnt);
        end
        tick();
        n_checks++;
        if (dup_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL dup_hold: dup=%0d, want 255", dup_cnt);
        end
    endtask

    task automatic test_reset_mid_grant();
        logic [7:0] exp_g;
`ifdef ARB_RR_EN
        exp_g = 8'h10;
`else
        exp_g = 8'h80;
`endif
        do_reset();
        req_in = 8'hF0;
        tick();
        req_in = '0;
        tick();
        n_checks++;
        if ({gnt_valid, gnt, pending} !== {1'b1, exp_g, 8'hF0}) begin
            n_fail++;
            $display("FAIL midrst_pre: v=%b gnt=%h pend=%h, want 1 %h F0", gnt_valid, gnt, pending, exp_g);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({gnt, gnt_valid, pending, dup_cnt} !== 25'd0) begin
            n_fail++;
            $display("FAIL midrst_clear: gnt=%h v=%b pend=%h dup=%0d, want all 0", gnt, gnt_valid, pending, dup_cnt);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            n_checks++;
            if ({gnt_valid, gnt} !== 9'd0) begin
                n_fail++;
                $display("FAIL midrst_idle cyc%0d: v=%b gnt=%h, want 0 00", c, gnt_valid, gnt);
            end
        end
    endtask

    initial begin
        rst = 1'b1; req_in = '0; gnt_ack = 1'b0;
        test_reset();
        test_single_grant();
        test_priority();
        test_ack_set_same_edge();
        test_dup_count();
        test_reset_mid_grant();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
